// File: rtl/sonar_scheduler_if.sv
// Sonar scheduler bundle: groups the enable input, the ranging-driver
// handshake and the per-sensor result outputs into one interface.
//   master : the scheduler (drives the measure/reset strobes, sel and results)
//   slave  : the environment (drives enable, drv_ready and drv_distance)
// Ports carried:
//   enable        run continuous round-robin scan
//   drv_ready     driver idle / distance stable
//   drv_distance  driver distance in cm
//   drv_measure   single-cycle start pulse to the driver
//   drv_rst       driver abort reset
//   sel           sensor currently muxed to the driver
//   dist_flat     latched distance per sensor, sensor i at [8i+7:8i]
//   valid         per-sensor completed-measurement flag
//   timeout       per-sensor last-attempt-aborted flag
//   frame_done    one-cycle pulse after the last sensor's slot
interface sonar_scheduler_if #(
  parameter int NUM_SENSORS = 4
);
  logic                       enable;
  logic                       drv_ready;
  logic [7:0]                 drv_distance;
  logic                       drv_measure;
  logic                       drv_rst;
  logic [2:0]                 sel;
  logic [8*NUM_SENSORS-1:0]   dist_flat;
  logic [NUM_SENSORS-1:0]     valid;
  logic [NUM_SENSORS-1:0]     timeout;
  logic                       frame_done;

  modport master (
    input  enable, drv_ready, drv_distance,
    output drv_measure, drv_rst, sel, dist_flat, valid, timeout, frame_done
  );

  modport slave (
    output enable, drv_ready, drv_distance,
    input  drv_measure, drv_rst, sel, dist_flat, valid, timeout, frame_done
  );
endinterface

// File: rtl/sonar_scheduler.sv
// Sonar scheduler: time-shares one ultrasonic ranging driver across
// NUM_SENSORS sensors in round-robin order, with an idle gap between
// measurements to keep echoes from one sensor out of the next.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  sonar_scheduler_if.master (enable, driver handshake, results)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | halted; leaves when enable and the driver is ready
// START   | drv_measure high for this single cycle
// ACK     | waiting for the driver to drop ready (bounded by ACK_CYCLES)
// BUSY    | measurement running (bounded by TIMEOUT_CYCLES)
// SETTLE  | one cycle for the distance output to settle
// CAPTURE | latch distance into slot sel, mark valid, clear timeout
// ABORT   | drv_rst high for two cycles, mark timeout for slot sel
// GAP     | anti-crosstalk idle, then advance sel
module sonar_scheduler #(
  parameter int NUM_SENSORS    = 4,
  parameter int GAP_CYCLES     = 3000000,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int ACK_CYCLES     = 4
) (
  input  logic                clk,
  input  logic                rst,
  sonar_scheduler_if.master   bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_BUSY    = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_ABORT   = 3'd6;
  localparam logic [2:0] S_GAP     = 3'd7;

  localparam int MAX_WAIT = (GAP_CYCLES > TIMEOUT_CYCLES) ?
                            ((GAP_CYCLES > ACK_CYCLES) ? GAP_CYCLES : ACK_CYCLES) :
                            ((TIMEOUT_CYCLES > ACK_CYCLES) ? TIMEOUT_CYCLES : ACK_CYCLES);
  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 22) ? $clog2(MAX_WAIT + 1) : 22;

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of an N-cycle window is the one where cnt == N-1.
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ABORT_LAST = CNT_W'(1);
  localparam logic [2:0]       SEL_LAST   = 3'(NUM_SENSORS - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             counting;
  logic             gap_done;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.enable && bus.drv_ready) state_nxt = S_START;
      S_START:   state_nxt = S_ACK;
      S_ACK: begin
        if (!bus.drv_ready)       state_nxt = S_BUSY;
        else if (cnt == ACK_LAST) state_nxt = S_ABORT;
      end
      S_BUSY: begin
        // A completion seen on the final busy cycle still wins over abort.
        if (bus.drv_ready)        state_nxt = S_SETTLE;
        else if (cnt == TMO_LAST) state_nxt = S_ABORT;
      end
      S_SETTLE:  state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_GAP;
      S_ABORT:   if (cnt == ABORT_LAST) state_nxt = S_GAP;
      S_GAP:     if (cnt == GAP_LAST) state_nxt = bus.enable ? S_START : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign counting = (state == S_ACK) || (state == S_BUSY) ||
                    (state == S_ABORT) || (state == S_GAP);
  assign gap_done = (state == S_GAP) && (cnt == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      // Every bounded state exits at its terminal count, so cnt never wraps.
      if (state_nxt != state) cnt <= '0;
      else if (counting)      cnt <= cnt + CNT_W'(1);
    end
  end

  // Strobes decode straight from the state, so they can never overlap and
  // drop immediately on reset.
  assign bus.drv_measure = (state == S_START);
  assign bus.drv_rst     = (state == S_ABORT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sel        <= '0;
      bus.dist_flat  <= '0;
      bus.valid      <= '0;
      bus.timeout    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= gap_done && (bus.sel == SEL_LAST);
      if (gap_done) bus.sel <= (bus.sel == SEL_LAST) ? 3'd0 : bus.sel + 3'd1;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        if (bus.sel == 3'(i)) begin
          if (state == S_CAPTURE) begin
            bus.dist_flat[8*i +: 8] <= bus.drv_distance;
            bus.valid[i]            <= 1'b1;
            bus.timeout[i]          <= 1'b0;
          end else if (state == S_ABORT) begin
            bus.timeout[i]          <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler. A behavioural driver responds
// to each measure pulse after a chosen ack delay with a chosen busy time;
// the expected slot outcome, slot length and result registers come from
// the scheduling rules expressed as plain arithmetic and arrays.
module tb_sonar_scheduler;
  localparam int N    = 2;
  localparam int GAP  = 10;
  localparam int TMO  = 50;
  localparam int ACK  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sonar_scheduler_if #(.NUM_SENSORS(N)) bus ();

  sonar_scheduler #(
    .NUM_SENSORS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .ACK_CYCLES(ACK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int            m_sel;
  logic [7:0]    m_dist [N];
  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0;
    m_valid = '0;
    m_timeout = '0;
    for (int i = 0; i < N; i++) m_dist[i] = 8'd0;
  endtask

  task automatic check_regs(input string tag);
    logic [8*N-1:0] f;
    for (int i = 0; i < N; i++) f[8*i +: 8] = m_dist[i];
    chk({tag, "_dist"},    32'(bus.dist_flat), 32'(f));
    chk({tag, "_valid"},   32'(bus.valid),     32'(m_valid));
    chk({tag, "_timeout"}, 32'(bus.timeout),   32'(m_timeout));
    chk({tag, "_sel"},     32'(bus.sel),       32'(m_sel));
  endtask

  task automatic wait_measure(input int bound, output int cycles);
    cycles = 0;
    while (!bus.drv_measure && cycles < bound) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Called at the negedge of a START cycle. a = cycles after the measure
  // pulse before ready drops, b = cycles ready stays low, d = distance.
  // drop_at >= 0 lowers enable at that relative cycle.
  task automatic do_slot(input int a, input int b, input logic [7:0] d,
                         input int drop_at, input string tag);
    int  cur, pred, rst_cyc, fd, both, next_r, limit;
    bit  cap, ack_ab, dead, en_keep;
    cur     = m_sel;
    ack_ab  = (a > ACK);
    cap     = !ack_ab && (b <= TMO);
    en_keep = (drop_at < 0);
    // Slot length from one START to the next: START + ack wait + busy +
    // SETTLE + CAPTURE + gap, or START + wait-until-abort + 2 abort + gap.
    if (cap)         pred = 1 + a + b + 1 + 1 + GAP;
    else if (ack_ab) pred = 1 + ACK + 2 + GAP;
    else             pred = 1 + a + TMO + 2 + GAP;
    limit   = en_keep ? pred + 5 : pred + 20;
    rst_cyc = 0; fd = 0; both = 0; next_r = -1; dead = 1'b0;
    chk({tag, "_start_sel"}, 32'(bus.sel), 32'(cur));
    for (int r = 1; r <= limit; r++) begin
      @(negedge clk);
      if (r == drop_at) bus.enable = 1'b0;
      if (bus.drv_rst) begin rst_cyc++; dead = 1'b1; end
      if (bus.drv_rst && bus.drv_measure) both++;
      if (bus.frame_done) fd++;
      if (bus.drv_measure && next_r < 0) next_r = r;
      bus.drv_ready    = dead || !(r >= a && r < a + b);
      bus.drv_distance = (r >= a + b) ? d : ~d;
      if (en_keep && bus.drv_measure) break;
    end
    if (cap) begin
      m_dist[cur]    = d;
      m_valid[cur]   = 1'b1;
      m_timeout[cur] = 1'b0;
    end else begin
      m_timeout[cur] = 1'b1;
    end
    m_sel = (cur + 1) % N;
    chk({tag, "_next_start"}, 32'(next_r), en_keep ? 32'(pred) : 32'hFFFF_FFFF);
    chk({tag, "_rst_cycles"}, 32'(rst_cyc), cap ? 32'd0 : 32'd2);
    chk({tag, "_overlap"},    32'(both), 32'd0);
    chk({tag, "_frame_done"}, 32'(fd), (cur == N - 1) ? 32'd1 : 32'd0);
    check_regs(tag);
  endtask

  initial begin
    int c;
    bit seen;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.drv_ready = 1'b1;
    bus.drv_distance = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_regs("reset");
    chk("reset_measure", 32'(bus.drv_measure), 32'd0);
    chk("reset_drv_rst", 32'(bus.drv_rst),     32'd0);
    chk("reset_frame",   32'(bus.frame_done),  32'd0);

    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.drv_measure) seen = 1'b1;
    end
    chk("idle_no_measure", 32'(seen), 32'd0);

    bus.enable = 1'b1;
    wait_measure(5, c);
    chk("first_start_latency", 32'(c), 32'd1);

    do_slot(1, 20, 8'd42, -1, "cap42");
    do_slot(1, 20, 8'd200, -1, "cap200");
    do_slot(1, 20, 8'd10, -1, "cap10");
    do_slot(1, 1000, 8'h77, -1, "busy_abort");
    do_slot(8, 10, 8'h33, -1, "ack_abort");
    do_slot(4, 50, 8'h99, -1, "edge_cap");
    do_slot(5, 1, 8'h11, -1, "edge_ack_abort");
    do_slot(1, 51, 8'h22, -1, "edge_busy_abort");
    do_slot(2, 1, 8'h44, -1, "short_cap");

    for (int k = 0; k < 10; k++) begin
      int a, b;
      a = $urandom_range(1, 6);
      b = $urandom_range(1, 60);
      do_slot(a, b, 8'($urandom), -1, $sformatf("rand%0d", k));
    end

    do_slot(2, 15, 8'h5C, 4, "enable_drop");
    bus.enable = 1'b1;
    wait_measure(5, c);
    chk("restart_latency", 32'(c), 32'd1);
    do_slot(3, 7, 8'hA5, -1, "after_restart");

    // Reset in the middle of a busy window.
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      bus.drv_ready = !(r >= 1 && r < 31);
    end
    rst = 1'b1;
    #1;
    model_reset();
    check_regs("mid_reset");
    chk("mid_reset_measure", 32'(bus.drv_measure), 32'd0);
    chk("mid_reset_drv_rst", 32'(bus.drv_rst),     32'd0);
    chk("mid_reset_frame",   32'(bus.frame_done),  32'd0);
    bus.drv_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.drv_rst) seen = 1'b1;
    end
    chk("mid_reset_no_abort", 32'(seen), 32'd0);
    rst = 1'b0;
    wait_measure(5, c);
    chk("post_reset_start", 32'(c), 32'd1);
    do_slot(1, 5, 8'h3C, -1, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, default 4, number of ultrasonic sensors time-shared on one ranging driver (2..8).
REQ-002 Parameter GAP_CYCLES, default 3000000, idle cycles between measurements (60 ms at 50 MHz, anti-crosstalk).
REQ-003 Parameter TIMEOUT_CYCLES, default 2500000, maximum cycles a measurement may stay busy before abort.
REQ-004 Parameter ACK_CYCLES, default 4, maximum cycles for the driver to drop ready after a measure pulse.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high = run continuous round-robin scan; low = finish current slot, then halt in IDLE.
REQ-008 drv_ready  input  1  driver idle indication; high = driver accepts measure, distance output stable.
REQ-009 drv_distance  input  8  driver distance in cm, valid while drv_ready high after completion.
REQ-010 drv_measure  output  1  single-cycle start pulse to the driver.
REQ-011 drv_rst  output  1  driver abort reset, used on ack failure or timeout.
REQ-012 sel  output  3  index of the sensor whose trig/echo are muxed to the driver.
REQ-013 dist_flat  output  8*NUM_SENSORS  latched distance per sensor; sensor i at bits [8i+7:8i].
REQ-014 valid  output  NUM_SENSORS  bit i high = dist_flat slot i holds a completed measurement.
REQ-015 timeout  output  NUM_SENSORS  bit i high = last attempt on sensor i aborted.
REQ-016 frame_done  output  1  single-cycle pulse after the last sensor's slot completes.

Function
REQ-017 States SHALL be IDLE, START, ACK, BUSY, SETTLE, CAPTURE, ABORT, GAP.
REQ-018 IDLE -> START when enable high and drv_ready high; otherwise stay.
REQ-019 START SHALL assert drv_measure for exactly one cycle, then go to ACK.
REQ-020 ACK -> BUSY when drv_ready low; -> ABORT if drv_ready still high after ACK_CYCLES cycles in ACK.
REQ-021 BUSY -> SETTLE when drv_ready high; -> ABORT when the busy counter reaches TIMEOUT_CYCLES.
REQ-022 SETTLE SHALL last one cycle; CAPTURE SHALL latch drv_distance into slot sel, set valid[sel], clear timeout[sel], then go to GAP.
REQ-023 ABORT SHALL assert drv_rst for 2 cycles, set timeout[sel], leave dist_flat slot sel and valid[sel] unchanged, then go to GAP.
REQ-024 GAP SHALL hold for GAP_CYCLES cycles, then advance sel and go to START when enable high, or to IDLE when enable low.
REQ-025 sel SHALL advance (sel+1) mod NUM_SENSORS, wrapping NUM_SENSORS-1 to 0; sel SHALL not change outside the GAP exit.
REQ-026 frame_done SHALL pulse for one cycle on the GAP exit when sel = NUM_SENSORS-1, whether the slot captured or aborted.
REQ-027 Timeout and gap counters SHALL be at least 22 bits wide and cleared on every state entry; no counter wraps.
REQ-028 enable dropping mid-slot SHALL not truncate the slot; the capture/abort and full gap complete first.
REQ-029 drv_measure and drv_rst SHALL never be high in the same cycle.
REQ-030 Latency from START to CAPTURE SHALL equal 1 + ACK wait + busy duration + 1 cycles.

Reset
REQ-031 On rst: state IDLE, sel 0, dist_flat all 0, valid 0, timeout 0, drv_measure 0, drv_rst 0, frame_done 0, counters 0.
REQ-032 Reset mid-measurement SHALL return to IDLE immediately with no drv_rst pulse and no slot update.

Verification (NUM_SENSORS=2, GAP_CYCLES=10, TIMEOUT_CYCLES=50, ACK_CYCLES=4)
REQ-033 Model drops ready 1 cycle after measure, raises after 20 cycles with distance 8'd42 -> dist_flat[7:0]=42, valid=2'b01, sel=1 after gap.
REQ-034 Two sensors return 10 and 200 -> dist_flat=16'hC80A, valid=2'b11, one frame_done pulse, sel wraps to 0.
REQ-035 Sensor 1 ready stays low -> abort at busy cycle 50, drv_rst high 2 cycles, timeout=2'b10, valid[1] and slot 1 unchanged.
REQ-036 Ready never drops after measure -> ABORT after 4 ACK cycles, timeout[sel]=1.
REQ-037 enable dropped during BUSY -> capture completes, gap of 10 cycles, then IDLE; no further drv_measure.
REQ-038 rst asserted in BUSY -> all outputs reset values next cycle, no drv_rst pulse; re-enable restarts at sel=0.
